ltpi_tx_scheduler: RTL and testbench
====================================

LTPI_TX_SCHEDULER -- requirements
Module: ltpi_tx_scheduler

Interface
REQ-001 Parameter FRAME_LEN, default 16: 10-bit symbols per granted frame, range 2..64.
REQ-002 Parameter IDLE_GAP, default 2: idle symbols inserted after every frame, range 0..15.
REQ-003 Parameter IDLE_SYM, default 10'h0FA: 10-bit idle/comma symbol.
REQ-004 clk  input  1  single clock; the PHY TX FIFO write clock.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 req  input  3  frame requests; bit0 training, bit1 control, bit2 data.
REQ-007 req_sym  input  30  symbol per requester; requester n drives bits [10n+9:10n].
REQ-008 req_sym_rd  output  3  one-hot pulse: requester's current symbol consumed this cycle.
REQ-009 gnt  output  3  one-hot one-cycle pulse marking frame start for the granted requester.
REQ-010 phy_tx_in  output  10  symbol to PHY TX FIFO.
REQ-011 phy_tx_dv  output  1  PHY FIFO write strobe.
REQ-012 txfifo_full  input  1  PHY TX FIFO full, same clock domain.
REQ-013 busy  output  1  high in SEND or GAP.
REQ-014 frame_done  output  1  one-cycle pulse on the cycle the last frame symbol is written.

Function
REQ-015 FSM states: IDLE, SEND, GAP; state, grant register, symbol counter and gap counter are registered.
REQ-016 phy_tx_dv, phy_tx_in, req_sym_rd and frame_done are combinational from registered state and txfifo_full; no write is ever issued in a cycle with txfifo_full=1.
REQ-017 IDLE with any req bit set -> SEND at the next edge; gnt pulses in that IDLE cycle; grant latched.
REQ-018 Arbitration: req[0] has strict priority; req[1]/req[2] round-robin, i.e. when both request, grant the one not served last.
REQ-019 Round-robin pointer updates only when req[1] or req[2] is granted; req[0] grants leave it unchanged.
REQ-020 SEND, txfifo_full=0: phy_tx_in=req_sym of granted requester, phy_tx_dv=1, req_sym_rd[g]=1, counter increments.
REQ-021 SEND, txfifo_full=1: phy_tx_dv=0, req_sym_rd=0, counter holds; no symbol is dropped or duplicated.
REQ-022 Write of symbol FRAME_LEN-1: frame_done=1; next state GAP if IDLE_GAP>0, else IDLE; counter clears to 0.
REQ-023 Once granted, a frame always completes; deassertion of req mid-frame is ignored.
REQ-024 GAP: writes IDLE_SYM on each cycle with txfifo_full=0; after IDLE_GAP writes -> IDLE; full stalls the count.
REQ-025 Requests arriving during SEND/GAP are held off until IDLE; back-to-back frames are separated by at least one IDLE cycle.
REQ-026 busy=1 exactly when state is SEND or GAP.

Reset
REQ-027 Reset (synchronous, active-high) forces state IDLE, counters 0, grant register 0, and round-robin pointer preferring req[1].
REQ-028 During reset and in the first cycle after it: gnt=0, req_sym_rd=0, phy_tx_dv=0, frame_done=0, busy=0, phy_tx_in=0.
REQ-029 Reset mid-frame abandons the frame immediately; no further symbol of it is written or consumed.

Configuration
REQ-030 Macro LTPI_TX_SCHED_IDLE_FILL_EN defined: in IDLE with no req and txfifo_full=0, phy_tx_in=IDLE_SYM and phy_tx_dv=1 (link kept alive).
REQ-031 Macro undefined: in IDLE phy_tx_dv=0 and phy_tx_in=0; GAP symbols are still sent.

Verification
REQ-032 req=3'b010 single, FRAME_LEN=16, full=0 -> gnt=010 once, 16 writes of req_sym[19:10], frame_done on 16th, 2 IDLE_SYM writes, busy low after.
REQ-033 req=3'b111 held continuously -> grant order 001,001,... ; with req[0] dropped after first frame -> 010, 100, 010 alternating.
REQ-034 txfifo_full high for 5 cycles at symbol 7 -> dv=0 and req_sym_rd=0 those 5 cycles; frame still yields exactly 16 writes in order.
REQ-035 reset asserted at symbol 9 -> dv=0 the next cycle, state IDLE, next req=3'b100 frame starts at symbol 0, pointer prefers req[1].
REQ-036 IDLE, req=0, full=0, macro defined -> dv=1 with 10'h0FA every cycle; macro undefined -> dv=0.

Source files
------------

// File: rtl/ltpi_tx_scheduler_if.sv
// Request/symbol/PHY-FIFO bundle between LTPI frame sources, the TX scheduler and the PHY TX FIFO.
interface ltpi_tx_scheduler_if;
  logic [2:0]  req;
  logic [29:0] req_sym;
  logic [2:0]  req_sym_rd;
  logic [2:0]  gnt;
  logic [9:0]  phy_tx_in;
  logic        phy_tx_dv;
  logic        txfifo_full;
  logic        busy;
  logic        frame_done;

  modport master (
    output req, req_sym, txfifo_full,
    input  req_sym_rd, gnt, phy_tx_in, phy_tx_dv, busy, frame_done
  );

  modport slave (
    input  req, req_sym, txfifo_full,
    output req_sym_rd, gnt, phy_tx_in, phy_tx_dv, busy, frame_done
  );
endinterface

// File: rtl/ltpi_tx_scheduler.sv
// LTPI TX frame scheduler: arbitrates training/control/data sources into fixed-length frames plus idle gaps.
// Optional LTPI_TX_SCHED_IDLE_FILL_EN keeps the link alive with IDLE_SYM writes while idle.
module ltpi_tx_scheduler #(
  parameter int unsigned FRAME_LEN = 16,
  parameter int unsigned IDLE_GAP  = 2,
  parameter logic [9:0]  IDLE_SYM  = 10'h0FA
) (
  input  logic                 clk,
  input  logic                 reset,
  ltpi_tx_scheduler_if.slave   bus
);

  localparam int unsigned CW = 6;
  localparam int unsigned GW = 4;
  localparam logic [CW-1:0] FRAME_LAST = CW'(FRAME_LEN - 1);
  localparam logic [GW-1:0] GAP_LAST   = GW'((IDLE_GAP == 0) ? 0 : IDLE_GAP - 1);

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP} state_t;

  state_t          state_q, state_d;
  logic [2:0]      grant_q, grant_d;
  logic [CW-1:0]   sym_cnt_q, sym_cnt_d;
  logic [GW-1:0]   gap_cnt_q, gap_cnt_d;
  logic            rr_q, rr_d;      // 0: prefer req[1], 1: prefer req[2]
  logic            first_q;         // first cycle after reset, outputs held quiet
  logic [2:0]      pick_c;
  logic [9:0]      gsym_c;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      grant_q   <= '0;
      sym_cnt_q <= '0;
      gap_cnt_q <= '0;
      rr_q      <= 1'b0;
      first_q   <= 1'b1;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      sym_cnt_q <= sym_cnt_d;
      gap_cnt_q <= gap_cnt_d;
      rr_q      <= rr_d;
      first_q   <= 1'b0;
    end
  end

  // Training has strict priority; control/data alternate when both ask.
  always_comb begin
    pick_c = '0;
    if (bus.req[0])                    pick_c = 3'b001;
    else if (bus.req[1] && bus.req[2]) pick_c = rr_q ? 3'b100 : 3'b010;
    else if (bus.req[1])               pick_c = 3'b010;
    else if (bus.req[2])               pick_c = 3'b100;
  end

  always_comb begin
    gsym_c = '0;
    case (grant_q)
      3'b001:  gsym_c = bus.req_sym[9:0];
      3'b010:  gsym_c = bus.req_sym[19:10];
      3'b100:  gsym_c = bus.req_sym[29:20];
      default: gsym_c = '0;
    endcase
  end

  always_comb begin
    state_d         = state_q;
    grant_d         = grant_q;
    sym_cnt_d       = sym_cnt_q;
    gap_cnt_d       = gap_cnt_q;
    rr_d            = rr_q;
    bus.gnt         = '0;
    bus.req_sym_rd  = '0;
    bus.phy_tx_in   = '0;
    bus.phy_tx_dv   = 1'b0;
    bus.frame_done  = 1'b0;
    bus.busy        = 1'b0;
    if (!reset) begin
      case (state_q)
        S_IDLE: begin
          if (!first_q && (pick_c != 3'b000)) begin
            bus.gnt   = pick_c;
            grant_d   = pick_c;
            sym_cnt_d = '0;
            state_d   = S_SEND;
            if (!pick_c[0]) rr_d = pick_c[1];
          end
`ifdef LTPI_TX_SCHED_IDLE_FILL_EN
          else if (!first_q && !bus.txfifo_full) begin
            bus.phy_tx_dv = 1'b1;
            bus.phy_tx_in = IDLE_SYM;
          end
`endif
        end
        S_SEND: begin
          bus.busy = 1'b1;
          if (!bus.txfifo_full) begin
            bus.phy_tx_dv  = 1'b1;
            bus.phy_tx_in  = gsym_c;
            bus.req_sym_rd = grant_q;
            if (sym_cnt_q == FRAME_LAST) begin
              bus.frame_done = 1'b1;
              sym_cnt_d      = '0;
              state_d        = (IDLE_GAP > 0) ? S_GAP : S_IDLE;
            end else begin
              sym_cnt_d = sym_cnt_q + CW'(1);
            end
          end
        end
        S_GAP: begin
          bus.busy = 1'b1;
          if (!bus.txfifo_full) begin
            bus.phy_tx_dv = 1'b1;
            bus.phy_tx_in = IDLE_SYM;
            if (gap_cnt_q == GAP_LAST) begin
              gap_cnt_d = '0;
              state_d   = S_IDLE;
            end else begin
              gap_cnt_d = gap_cnt_q + GW'(1);
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ltpi_tx_scheduler.sv
// Self-checking bench for ltpi_tx_scheduler: frame-slot model compared every cycle plus directed literal checks.
module tb_ltpi_tx_scheduler;
  localparam int unsigned FL = 16;
  localparam int unsigned IG = 2;
  localparam logic [9:0]  ISYM = 10'h0FA;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  ltpi_tx_scheduler_if bus ();
  ltpi_tx_scheduler #(.FRAME_LEN(FL), .IDLE_GAP(IG), .IDLE_SYM(ISYM)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  int total, bad;
  // Model: a frame occupies FL data slots then IG gap slots; a slot advances on every non-full cycle.
  int m_active, m_owner, m_pos, m_last, m_fresh;
  int exp_seq [3];
  int src [3];
  logic [2:0] rd_seen;
  int n_data, n_gap, n_fd, n_gnt, n_dv;
  logic [2:0] gnt_log [$];

  assign bus.req_sym = {10'(512 + src[2]), 10'(256 + src[1]), 10'(src[0])};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic int pick(input logic [2:0] r, input int last);
    if (r[0]) return 0;
    if (r[1] && r[2]) return (last == 1) ? 2 : 1;
    if (r[1]) return 1;
    if (r[2]) return 2;
    return -1;
  endfunction

  task automatic check_cycle();
    logic [2:0] e_gnt = '0, e_rd = '0;
    logic e_dv = 1'b0, e_fd = 1'b0, e_busy = 1'b0;
    logic [9:0] e_in = '0;
    bit cmp_in = 1'b1;
    int p;
    if (!reset && m_fresh == 0) begin
      if (m_active == 0) begin
        p = pick(bus.req, m_last);
        if (p >= 0) e_gnt = 3'(1 << p);
`ifdef LTPI_TX_SCHED_IDLE_FILL_EN
        else if (!bus.txfifo_full) begin e_dv = 1'b1; e_in = ISYM; end
`endif
      end else begin
        e_busy = 1'b1;
        if (!bus.txfifo_full) begin
          e_dv = 1'b1;
          if (m_pos < int'(FL)) begin
            e_in = 10'(m_owner * 256 + exp_seq[m_owner]);
            e_rd = 3'(1 << m_owner);
            e_fd = (m_pos == int'(FL) - 1);
          end else begin
            e_in = ISYM;
          end
        end else begin
          cmp_in = 1'b0;
        end
      end
    end
    chk("gnt", bus.gnt, e_gnt);
    chk("req_sym_rd", bus.req_sym_rd, e_rd);
    chk("phy_tx_dv", bus.phy_tx_dv, e_dv);
    chk("frame_done", bus.frame_done, e_fd);
    chk("busy", bus.busy, e_busy);
    if (cmp_in) chk("phy_tx_in", bus.phy_tx_in, e_in);
    if (bus.gnt != 3'b000) begin n_gnt++; gnt_log.push_back(bus.gnt); end
    if (bus.req_sym_rd != 3'b000) n_data++;
    if (bus.phy_tx_dv && bus.busy && bus.req_sym_rd == 3'b000) n_gap++;
    if (bus.frame_done) n_fd++;
    if (bus.phy_tx_dv) n_dv++;
    rd_seen = bus.req_sym_rd;
  endtask

  task automatic model_step();
    int p;
    for (int n = 0; n < 3; n++) src[n] += int'(rd_seen[n]);
    if (reset) begin
      m_active = 0; m_pos = 0; m_last = 2; m_fresh = 1;
    end else if (m_fresh != 0) begin
      m_fresh = 0;
    end else if (m_active == 0) begin
      p = pick(bus.req, m_last);
      if (p >= 0) begin
        m_active = 1; m_owner = p; m_pos = 0;
        if (p != 0) m_last = p;
      end
    end else if (!bus.txfifo_full) begin
      if (m_pos < int'(FL)) exp_seq[m_owner]++;
      m_pos++;
      if (m_pos == int'(FL + IG)) m_active = 0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic wait_writes(input int target, input int base);
    int k = 0;
    while ((n_data - base) < target && k < 200) begin tick(); k++; end
    if (k >= 200) chk("wait_writes_timeout", 32'(n_data - base), 32'(target));
  endtask

  task automatic wait_idle();
    int k = 0;
    tick();
    while (bus.busy && k < 100) begin tick(); k++; end
    if (k >= 100) chk("wait_idle_timeout", 32'(bus.busy), 32'd0);
    tick();
  endtask

  task automatic wait_gnts(input int target, input int base);
    int k = 0;
    while ((n_gnt - base) < target && k < 200) begin tick(); k++; end
    if (k >= 200) chk("wait_gnt_timeout", 32'(n_gnt - base), 32'(target));
  endtask

  initial begin
    int b, g, f, gn, s, s2, d;
    logic [2:0] exp_order [6] = '{3'b001, 3'b001, 3'b001, 3'b010, 3'b100, 3'b010};
    reset = 1'b1;
    bus.req = '0;
    bus.txfifo_full = 1'b0;
    total = 0; bad = 0;
    m_active = 0; m_owner = 0; m_pos = 0; m_last = 2; m_fresh = 1;
    rd_seen = '0;
    n_data = 0; n_gap = 0; n_fd = 0; n_gnt = 0; n_dv = 0;
    for (int n = 0; n < 3; n++) begin exp_seq[n] = 0; src[n] = 0; end
    fork
      forever begin @(negedge clk); check_cycle(); end
      forever begin @(posedge clk); model_step(); end
    join_none

    // Reset state
    tick();
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_dv", bus.phy_tx_dv, 1'b0);
    chk("rst_tx_in", bus.phy_tx_in, 10'h000);
    do_reset();

    // Single control frame
    b = n_data; g = n_gap; f = n_fd; gn = n_gnt; s = src[1];
    bus.req = 3'b010;
    tick();
    bus.req = 3'b000;
    repeat (25) tick();
    chk("t1_gnt_count", 32'(n_gnt - gn), 32'd1);
    chk("t1_gnt_value", gnt_log[gnt_log.size() - 1], 3'b010);
    chk("t1_data_writes", 32'(n_data - b), 32'd16);
    chk("t1_src1_consumed", 32'(src[1] - s), 32'd16);
    chk("t1_gap_writes", 32'(n_gap - g), 32'd2);
    chk("t1_frame_done", 32'(n_fd - f), 32'd1);
    chk("t1_busy_after", bus.busy, 1'b0);

    // Priority then round-robin
    do_reset();
    gn = n_gnt; s = gnt_log.size();
    bus.req = 3'b111;
    wait_gnts(3, gn);
    bus.req = 3'b110;
    wait_gnts(6, gn);
    bus.req = 3'b000;
    wait_idle();
    for (int i = 0; i < 6; i++)
      if (s + i < gnt_log.size()) chk($sformatf("t2_order_%0d", i), gnt_log[s + i], exp_order[i]);
      else chk($sformatf("t2_order_missing_%0d", i), 32'(gnt_log.size()), 32'(s + i + 1));

    // Back-pressure at symbol 7
    do_reset();
    b = n_data; s2 = src[2];
    bus.req = 3'b100;
    tick();
    bus.req = 3'b000;
    wait_writes(7, b);
    bus.txfifo_full = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("t3_stall_dv", bus.phy_tx_dv, 1'b0);
      chk("t3_stall_rd", bus.req_sym_rd, 3'b000);
      tick();
    end
    bus.txfifo_full = 1'b0;
    wait_idle();
    chk("t3_data_writes", 32'(n_data - b), 32'd16);
    chk("t3_src2_consumed", 32'(src[2] - s2), 32'd16);

    // Reset mid-frame; pointer returns to preferring req[1]
    do_reset();
    bus.req = 3'b010;
    tick();
    bus.req = 3'b000;
    wait_idle();
    b = n_data;
    bus.req = 3'b001;
    tick();
    bus.req = 3'b000;
    wait_writes(9, b);
    reset = 1'b1;
    #1;
    chk("t4_rst_dv", bus.phy_tx_dv, 1'b0);
    chk("t4_rst_rd", bus.req_sym_rd, 3'b000);
    tick();
    reset = 1'b0;
    #1;
    chk("t4_first_busy", bus.busy, 1'b0);
    chk("t4_first_dv", bus.phy_tx_dv, 1'b0);
    tick();
    chk("t4_abandoned_writes", 32'(n_data - b), 32'd9);
    bus.req = 3'b110;
    tick();
    bus.req = 3'b000;
    chk("t4_rr_after_reset", gnt_log[gnt_log.size() - 1], 3'b010);
    wait_idle();
    b = n_data; f = n_fd;
    bus.req = 3'b100;
    tick();
    bus.req = 3'b000;
    chk("t4_gnt_data", gnt_log[gnt_log.size() - 1], 3'b100);
    wait_idle();
    chk("t4_data_writes", 32'(n_data - b), 32'd16);
    chk("t4_frame_done", 32'(n_fd - f), 32'd1);

    // Idle behaviour
    do_reset();
    d = n_dv;
    #1;
`ifdef LTPI_TX_SCHED_IDLE_FILL_EN
    chk("t5_idle_sym", bus.phy_tx_in, ISYM);
`else
    chk("t5_idle_sym", bus.phy_tx_in, 10'h000);
`endif
    repeat (5) tick();
`ifdef LTPI_TX_SCHED_IDLE_FILL_EN
    chk("t5_idle_dv_count", 32'(n_dv - d), 32'd5);
`else
    chk("t5_idle_dv_count", 32'(n_dv - d), 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
